// File: rtl/scan_display_if.sv
// Value/strobe bus between the counter side and the scanned 7-segment driver.
interface scan_display_if;
  logic [7:0]  value;
  logic        value_valid;
  logic        blank_lz;
  logic        hex_mode;
  logic        busy;
  logic [11:0] bcd;
  logic [6:0]  seg;
  logic [2:0]  dig;

  modport master (output value, value_valid, blank_lz, hex_mode,
                  input  busy, bcd, seg, dig);
  modport slave  (input  value, value_valid, blank_lz, hex_mode,
                  output busy, bcd, seg, dig);
endinterface

// File: rtl/scan_display_driver.sv
// 8-bit binary -> 3-digit BCD (shift-add-3) with a prescaled, multiplexed 7-seg scan.
// Optional macro SCAN_HEX_EN: hex_mode bypasses conversion and A-F glyphs decode.
module scan_display_driver #(
  parameter int SCAN_DIV       = 50000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input logic           clk,
  input logic           clr,
  scan_display_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

  localparam int       PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam bit       ACT_LOW = (SEG_ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_OFF = ACT_LOW ? 7'h7F : 7'h00;
  localparam logic [2:0] DIG_OFF = ACT_LOW ? 3'h7  : 3'h0;

  state_t      state, state_nxt;
  logic [7:0]  shift;
  logic [11:0] scratch, adj, bcd_r;
  logic [2:0]  iter;
  logic        hex_take;

`ifdef SCAN_HEX_EN
  assign hex_take = bus.hex_mode;
`else
  logic unused_hex;
  assign hex_take   = 1'b0;
  assign unused_hex = bus.hex_mode;
`endif

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'h3F;  4'h1: decode = 7'h06;
      4'h2: decode = 7'h5B;  4'h3: decode = 7'h4F;
      4'h4: decode = 7'h66;  4'h5: decode = 7'h6D;
      4'h6: decode = 7'h7D;  4'h7: decode = 7'h07;
      4'h8: decode = 7'h7F;  4'h9: decode = 7'h6F;
`ifdef SCAN_HEX_EN
      4'hA: decode = 7'h77;  4'hB: decode = 7'h7C;
      4'hC: decode = 7'h39;  4'hD: decode = 7'h5E;
      4'hE: decode = 7'h79;  4'hF: decode = 7'h71;
`endif
      default: decode = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.value_valid) state_nxt = hex_take ? LOAD : CONV;
      CONV: if (iter == 3'd7)    state_nxt = LOAD;
      LOAD: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every scratch nibble that would overflow after doubling
  always_comb begin
    for (int i = 0; i < 3; i++)
      adj[i*4 +: 4] = (scratch[i*4 +: 4] >= 4'd5) ? scratch[i*4 +: 4] + 4'd3
                                                  : scratch[i*4 +: 4];
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      shift   <= '0;
      scratch <= '0;
      iter    <= '0;
      bcd_r   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.value_valid) begin
          shift   <= bus.value;
          scratch <= hex_take ? {4'h0, bus.value} : 12'h000;
          iter    <= '0;
        end
        CONV: begin
          scratch <= {adj[10:0], shift[7]};
          shift   <= {shift[6:0], 1'b0};
          iter    <= iter + 3'd1;
        end
        LOAD: bcd_r <= scratch;
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.bcd  = bcd_r;

  logic [PW-1:0] presc;
  logic [1:0]    idx;
  logic [3:0]    nib;
  logic          blank;
  logic [2:0]    onehot;
  logic [6:0]    seg_raw;

  always_ff @(posedge clk) begin
    if (clr) begin
      presc <= '0;
      idx   <= '0;
    end else if (presc == PW'(SCAN_DIV - 1)) begin
      presc <= '0;
      idx   <= (idx >= 2'd2) ? 2'd0 : idx + 2'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Unreachable index 3 falls into the default and displays the ones digit
  always_comb begin
    nib    = bcd_r[3:0];
    blank  = 1'b0;
    onehot = 3'b001;
    case (idx)
      2'd1: begin
        nib    = bcd_r[7:4];
        blank  = bus.blank_lz && (bcd_r[11:8] == 4'h0) && (bcd_r[7:4] == 4'h0);
        onehot = 3'b010;
      end
      2'd2: begin
        nib    = bcd_r[11:8];
        blank  = bus.blank_lz && (bcd_r[11:8] == 4'h0);
        onehot = 3'b100;
      end
      default: ;
    endcase
    seg_raw = blank ? 7'h00 : decode(nib);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      bus.seg <= SEG_OFF;
      bus.dig <= DIG_OFF;
    end else begin
      bus.seg <= ACT_LOW ? ~seg_raw : seg_raw;
      bus.dig <= ACT_LOW ? ~onehot  : onehot;
    end
  end
endmodule

// File: tb/tb_scan_display_driver.sv
// Randomized bench for scan_display_driver against a cycle-count reference model.
module tb_scan_display_driver;
  localparam int DIV = 4;
  localparam int POL = 1;
`ifdef SCAN_HEX_EN
  localparam bit HEXEN = 1'b1;
`else
  localparam bit HEXEN = 1'b0;
`endif
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D,
    7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic clk = 1'b0;
  logic clr = 1'b1;
  scan_display_if bus();

  scan_display_driver #(.SCAN_DIV(DIV), .SEG_ACTIVE_LOW(POL)) dut (
    .clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  function automatic logic [11:0] ref_conv(input logic [7:0] v, input logic hx);
    int n;
    n = int'(v);
    if (hx) return {4'h0, v};
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  // A position is blank if blanking is on, it is not the ones place, and it and
  // every higher position are zero.
  function automatic logic [6:0] ref_seg(input logic [11:0] b, input logic blz, input int p);
    logic [3:0] d;
    bit lead;
    lead = 1'b1;
    for (int q = 2; q >= p; q--) if (b[q*4 +: 4] != 4'h0) lead = 1'b0;
    d = b[p*4 +: 4];
    if (blz && p > 0 && lead) return 7'h00;
    if (d > 4'd9 && !HEXEN) return 7'h00;
    return DEC[d];
  endfunction

  function automatic logic [6:0] pol7(input logic [6:0] x);
    return (POL != 0) ? ~x : x;
  endfunction
  function automatic logic [2:0] pol3(input logic [2:0] x);
    return (POL != 0) ? ~x : x;
  endfunction

  logic [6:0]  exp_seg;
  logic [2:0]  exp_dig;
  logic [11:0] m_bcd, m_pend;
  int          m_rem, m_t;

  always @(posedge clk) begin
    if (clr) begin
      exp_seg <= pol7(7'h00);
      exp_dig <= pol3(3'h0);
      m_bcd   <= '0;
      m_rem   <= 0;
      m_t     <= 0;
    end else begin
      exp_seg <= pol7(ref_seg(m_bcd, bus.blank_lz, (m_t / DIV) % 3));
      exp_dig <= pol3(3'(1 << ((m_t / DIV) % 3)));
      m_t     <= m_t + 1;
      if (m_rem == 0) begin
        if (bus.value_valid) begin
          m_rem  <= (HEXEN && bus.hex_mode) ? 1 : 9;
          m_pend <= ref_conv(bus.value, HEXEN && bus.hex_mode);
        end
      end else begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) m_bcd <= m_pend;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checks += 4;
      if (bus.busy !== (m_rem != 0)) begin
        errors++; $display("FAIL busy t=%0t got %b exp %b", $time, bus.busy, m_rem != 0);
      end
      if (bus.bcd !== m_bcd) begin
        errors++; $display("FAIL bcd t=%0t got %h exp %h", $time, bus.bcd, m_bcd);
      end
      if (bus.seg !== exp_seg) begin
        errors++; $display("FAIL seg t=%0t got %h exp %h", $time, bus.seg, exp_seg);
      end
      if (bus.dig !== exp_dig) begin
        errors++; $display("FAIL dig t=%0t got %b exp %b", $time, bus.dig, exp_dig);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++; $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] v, input logic hx);
    @(posedge clk); #1;
    bus.value = v; bus.value_valid = 1'b1; bus.hex_mode = hx;
    @(posedge clk); #1;
    bus.value_valid = 1'b0; bus.hex_mode = 1'b0;
  endtask

  task automatic busy_cycles(output int n);
    n = 0;
    repeat (12) begin @(negedge clk); if (bus.busy) n++; end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (bus.busy && k < 40) begin @(negedge clk); k++; end
    if (bus.busy) begin errors++; checks++; $display("FAIL idle_timeout got busy exp idle"); end
  endtask

  // Waits for a fresh slot of digit p and checks its active-high glyph
  task automatic lit_digit(input string name, input int p, input logic [6:0] raw);
    logic [2:0] tgt;
    int k;
    tgt = pol3(3'(1 << p));
    k = 0;
    do begin @(negedge clk); k++; end while (bus.dig === tgt && k < 40);
    do begin @(negedge clk); k++; end while (bus.dig !== tgt && k < 80);
    if (bus.dig !== tgt) check({name, "_timeout"}, 32'(bus.dig), 32'(tgt));
    else check(name, 32'(pol7(bus.seg)), 32'(raw));
  endtask

  initial begin
    int n;
    bus.value = '0; bus.value_valid = 1'b0; bus.blank_lz = 1'b0; bus.hex_mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 clr = 1'b0; chk_en = 1'b1;
    @(negedge clk);
    check("rst_seg", 32'(bus.seg), 32'h7F);
    check("rst_dig", 32'(bus.dig), 32'h7);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_bcd", 32'(bus.bcd), 32'h000);

    send(8'hFF, 1'b0);
    busy_cycles(n);
    check("ff_busy_len", 32'(n), 32'd9);
    check("ff_bcd", 32'(bus.bcd), 32'h255);
    lit_digit("ff_ones", 0, 7'h6D);
    lit_digit("ff_tens", 1, 7'h6D);
    lit_digit("ff_hund", 2, 7'h5B);

    bus.blank_lz = 1'b1;
    send(8'd7, 1'b0); wait_idle();
    lit_digit("b7_hund", 2, 7'h00);
    lit_digit("b7_tens", 1, 7'h00);
    lit_digit("b7_ones", 0, 7'h07);
    bus.blank_lz = 1'b0;
    lit_digit("u7_hund", 2, 7'h3F);
    lit_digit("u7_tens", 1, 7'h3F);
    lit_digit("u7_ones", 0, 7'h07);

    bus.blank_lz = 1'b1;
    send(8'd100, 1'b0); wait_idle();
    check("h100_bcd", 32'(bus.bcd), 32'h100);
    lit_digit("h100_ones", 0, 7'h3F);
    lit_digit("h100_tens", 1, 7'h3F);
    lit_digit("h100_hund", 2, 7'h06);

    @(posedge clk); #1 bus.value = 8'd12; bus.value_valid = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 0 || i == 3) bus.value_valid = 1'b0;
      if (i == 2) begin bus.value = 8'd200; bus.value_valid = 1'b1; end
      @(negedge clk); if (bus.busy) n++;
    end
    check("drop_busy_len", 32'(n), 32'd9);
    check("drop_bcd", 32'(bus.bcd), 32'h012);

    send(8'h55, 1'b0);
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    @(negedge clk);
    check("abort_busy", 32'(bus.busy), 32'h0);
    check("abort_bcd", 32'(bus.bcd), 32'h000);
    check("abort_seg", 32'(bus.seg), 32'h7F);
    check("abort_dig", 32'(bus.dig), 32'h7);

    bus.blank_lz = 1'b1;
    send(8'hAB, 1'b1);
    busy_cycles(n);
    check("hex_busy_len", 32'(n), HEXEN ? 32'd1 : 32'd9);
    check("hex_bcd", 32'(bus.bcd), HEXEN ? 32'h0AB : 32'h171);
    lit_digit("hex_ones", 0, HEXEN ? 7'h7C : 7'h06);
    lit_digit("hex_tens", 1, HEXEN ? 7'h77 : 7'h07);
    lit_digit("hex_hund", 2, HEXEN ? 7'h00 : 7'h06);

    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      bus.value       = 8'($urandom);
      bus.value_valid = ($urandom_range(0, 5) == 0);
      bus.blank_lz    = 1'($urandom);
      bus.hex_mode    = 1'($urandom);
      clr             = ($urandom_range(0, 99) == 0);
    end
    @(posedge clk); #1 clr = 1'b0; bus.value_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
